mips_encode: RTL and testbench

Instruction encoder for the single-cycle MIPS datapath: the inverse of the instruction decoder. Accepts one symbolic instruction per handshake (operation select, register numbers, 32-bit immediate/target) and emits the 32-bit machine word on a valid/ready stream toward instruction memory or the test loader. Expands the `li` pseudo-instruction into one or two words. Flags unsupported operations.

---
 rtl/mips_enc_pkg.sv | 60 ++++++
 rtl/mips_enc_word.sv | 108 ++++++++++
 rtl/mips_encode.sv | 100 ++++++++++
 tb/tb_mips_encode.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_enc_pkg.sv
// Shared types and opcode constants for the MIPS instruction encoder.
// Optional immediate range checking: MIPS_ENCODE_RANGE_CHECK_EN.
package mips_enc_pkg;

   typedef enum logic [4:0] {
      ENC_ADD, ENC_SUB, ENC_AND, ENC_OR,
      ENC_NOR, ENC_XOR, ENC_SLT, ENC_ADDM,
      ENC_JR, ENC_ADDI, ENC_ANDI, ENC_ORI,
      ENC_XORI, ENC_LW, ENC_LBU, ENC_SW,
      ENC_SB, ENC_BEQ, ENC_BNE, ENC_LUI,
      ENC_J, ENC_LI
   } enc_op_t;

   typedef enum logic [1:0] {
      S_EMPTY, S_ONE, S_PAIR
   } state_t;

   localparam logic [5:0] OP_OTHER0 = 6'h00;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ANDI   = 6'h0c;
   localparam logic [5:0] OP_ORI    = 6'h0d;
   localparam logic [5:0] OP_XORI   = 6'h0e;
   localparam logic [5:0] OP_LUI    = 6'h0f;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_LBU    = 6'h24;
   localparam logic [5:0] OP_SB     = 6'h28;
   localparam logic [5:0] OP_SW     = 6'h2b;

   localparam logic [5:0] OP0_JR    = 6'h08;
   localparam logic [5:0] OP0_ADD   = 6'h20;
   localparam logic [5:0] OP0_SUB   = 6'h22;
   localparam logic [5:0] OP0_AND   = 6'h24;
   localparam logic [5:0] OP0_OR    = 6'h25;
   localparam logic [5:0] OP0_XOR   = 6'h26;
   localparam logic [5:0] OP0_NOR   = 6'h27;
   localparam logic [5:0] OP0_SLT   = 6'h2a;
   localparam logic [5:0] OP0_ADDM  = 6'h2c;

   function automatic logic [31:0] rtype(
      input logic [4:0] rs,
      input logic [4:0] rt,
      input logic [4:0] rd,
      input logic [5:0] funct
   );
      return {OP_OTHER0, rs, rt, rd, 5'b0, funct};
   endfunction

   function automatic logic [31:0] itype(
      input logic [5:0]  op,
      input logic [4:0]  rs,
      input logic [4:0]  rt,
      input logic [15:0] imm
   );
      return {op, rs, rt, imm};
   endfunction

endpackage

// File: rtl/mips_enc_word.sv
// Combinational word builder: one symbolic request to one or two words.
// Range errors are flagged only when MIPS_ENCODE_RANGE_CHECK_EN is defined.
module mips_enc_word
   import mips_enc_pkg::*;
(
   input  logic [4:0]  op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [31:0] imm,
   output logic [31:0] word0,
   output logic [31:0] word1,
   output logic        two_words,
   output logic        bad
);

   logic sx_bad;
   logic zx_bad;
   logic j_bad;

`ifdef MIPS_ENCODE_RANGE_CHECK_EN
   assign sx_bad = ~((&imm[31:15]) | ~(|imm[31:15]));
   assign zx_bad = |imm[31:16];
   assign j_bad  = (|imm[1:0]) | (|imm[31:28]);
`else
   assign sx_bad = 1'b0;
   assign zx_bad = 1'b0;
   assign j_bad  = 1'b0;
`endif

   always_comb begin
      word0     = '0;
      word1     = '0;
      two_words = 1'b0;
      bad       = 1'b0;
      unique case (enc_op_t'(op))
         ENC_ADD:  word0 = rtype(rs, rt, rd, OP0_ADD);
         ENC_SUB:  word0 = rtype(rs, rt, rd, OP0_SUB);
         ENC_AND:  word0 = rtype(rs, rt, rd, OP0_AND);
         ENC_OR:   word0 = rtype(rs, rt, rd, OP0_OR);
         ENC_NOR:  word0 = rtype(rs, rt, rd, OP0_NOR);
         ENC_XOR:  word0 = rtype(rs, rt, rd, OP0_XOR);
         ENC_SLT:  word0 = rtype(rs, rt, rd, OP0_SLT);
         ENC_ADDM: word0 = rtype(rs, rt, rd, OP0_ADDM);
         ENC_JR:   word0 = {OP_OTHER0, rs, 15'b0, OP0_JR};
         ENC_ADDI: begin
            word0 = itype(OP_ADDI, rs, rt, imm[15:0]);
            bad   = sx_bad;
         end
         ENC_ANDI: begin
            word0 = itype(OP_ANDI, rs, rt, imm[15:0]);
            bad   = zx_bad;
         end
         ENC_ORI: begin
            word0 = itype(OP_ORI, rs, rt, imm[15:0]);
            bad   = zx_bad;
         end
         ENC_XORI: begin
            word0 = itype(OP_XORI, rs, rt, imm[15:0]);
            bad   = zx_bad;
         end
         ENC_LW: begin
            word0 = itype(OP_LW, rs, rt, imm[15:0]);
            bad   = sx_bad;
         end
         ENC_LBU: begin
            word0 = itype(OP_LBU, rs, rt, imm[15:0]);
            bad   = sx_bad;
         end
         ENC_SW: begin
            word0 = itype(OP_SW, rs, rt, imm[15:0]);
            bad   = sx_bad;
         end
         ENC_SB: begin
            word0 = itype(OP_SB, rs, rt, imm[15:0]);
            bad   = sx_bad;
         end
         ENC_BEQ: begin
            word0 = itype(OP_BEQ, rs, rt, imm[15:0]);
            bad   = sx_bad;
         end
         ENC_BNE: begin
            word0 = itype(OP_BNE, rs, rt, imm[15:0]);
            bad   = sx_bad;
         end
         ENC_LUI: begin
            word0 = itype(OP_LUI, 5'd0, rt, imm[15:0]);
            bad   = zx_bad;
         end
         ENC_J: begin
            word0 = {OP_J, imm[27:2]};
            bad   = j_bad;
         end
         ENC_LI: begin
            // Small constants need only the ORI from $0.
            if (imm[31:16] == 16'd0) begin
               word0 = itype(OP_ORI, 5'd0, rt, imm[15:0]);
            end else begin
               word0     = itype(OP_LUI, 5'd0, rt, imm[31:16]);
               word1     = itype(OP_ORI, rt, rt, imm[15:0]);
               two_words = 1'b1;
            end
         end
         default: bad = 1'b1;
      endcase
   end

endmodule

// File: rtl/mips_encode.sv
// Instruction encoder top: request stream in, machine-word stream out.
// Optional immediate range checking: MIPS_ENCODE_RANGE_CHECK_EN.
module mips_encode
   import mips_enc_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_op,
   input  logic [4:0]  req_rs,
   input  logic [4:0]  req_rt,
   input  logic [4:0]  req_rd,
   input  logic [31:0] req_imm,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst,
   output logic        inst_last,
   output logic        err,
   output logic [15:0] inst_count
);

   state_t      state;
   state_t      state_nx;
   logic [31:0] word0;
   logic [31:0] word1;
   logic        two_words;
   logic        bad;
   logic [31:0] hold;
   logic        acc;
   logic        load_new;
   logic        take_hold;

   mips_enc_word u_word (
      .op        (req_op),
      .rs        (req_rs),
      .rt        (req_rt),
      .rd        (req_rd),
      .imm       (req_imm),
      .word0     (word0),
      .word1     (word1),
      .two_words (two_words),
      .bad       (bad)
   );

   assign inst_valid = (state != S_EMPTY);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_EMPTY;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      req_ready = 1'b0;
      load_new  = 1'b0;
      take_hold = 1'b0;
      unique case (state)
         S_EMPTY: req_ready = 1'b1;
         S_ONE:   req_ready = inst_ready;
         S_PAIR:  req_ready = 1'b0;
         default: req_ready = 1'b0;
      endcase
      acc = req_valid & req_ready;
      if (state == S_PAIR) begin
         if (inst_ready) begin
            state_nx  = S_ONE;
            take_hold = 1'b1;
         end
      end else if (acc & ~bad) begin
         state_nx = two_words ? S_PAIR : S_ONE;
         load_new = 1'b1;
      end else if (state == S_ONE && inst_ready) begin
         state_nx = S_EMPTY;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inst       <= '0;
         inst_last  <= 1'b0;
         hold       <= '0;
         err        <= 1'b0;
         inst_count <= '0;
      end else begin
         err <= acc & bad;
         if (inst_valid & inst_ready)
            inst_count <= inst_count + 16'd1;
         if (take_hold) begin
            inst      <= hold;
            inst_last <= 1'b1;
         end else if (load_new) begin
            inst      <= word0;
            inst_last <= ~two_words;
            hold      <= word1;
         end
      end
   end

endmodule

// File: tb/tb_mips_encode.sv
// Randomized scoreboard bench for mips_encode with directed opening cases.
// Honours MIPS_ENCODE_RANGE_CHECK_EN in its reference model.
module tb_mips_encode;
   import mips_enc_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_op;
   logic [4:0]  req_rs;
   logic [4:0]  req_rt;
   logic [4:0]  req_rd;
   logic [31:0] req_imm;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic        inst_last;
   logic        err;
   logic [15:0] inst_count;

   int          n_total = 0;
   int          n_bad   = 0;
   logic [32:0] q[$];
   logic [15:0] cnt_exp = '0;
   logic        err_exp = 1'b0;

   always #5 clk = ~clk;

   mips_encode dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_rs     (req_rs),
      .req_rt     (req_rt),
      .req_rd     (req_rd),
      .req_imm    (req_imm),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .inst       (inst),
      .inst_last  (inst_last),
      .err        (err),
      .inst_count (inst_count)
   );

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h want=%h", tag, got, exp);
      end
   endtask

   // Reference: number of words (0 = error) and the words themselves.
   function automatic void ref_enc(
      input  logic [4:0]  op,
      input  logic [4:0]  rs,
      input  logic [4:0]  rt,
      input  logic [4:0]  rd,
      input  logic [31:0] imm,
      output int          n,
      output logic [31:0] w0,
      output logic [31:0] w1
   );
      int unsigned o, f, s, t, d, lo, hi;
      bit sx, zx, jx;
      int kind;
      s  = rs; t = rt; d = rd;
      lo = imm % 65536;
      hi = imm / 65536;
      sx = ($signed(imm) < -32768) || ($signed(imm) > 32767);
      zx = (imm >= 32'h10000);
      jx = (imm % 4 != 0) || (imm >= 32'h1000_0000);
`ifndef MIPS_ENCODE_RANGE_CHECK_EN
      sx = 0; zx = 0; jx = 0;
`endif
      n = 1; w0 = 0; w1 = 0; o = 0; f = 0; kind = 2;
      case (op)
         ENC_ADD:  begin kind = 0; f = 32; end
         ENC_SUB:  begin kind = 0; f = 34; end
         ENC_AND:  begin kind = 0; f = 36; end
         ENC_OR:   begin kind = 0; f = 37; end
         ENC_XOR:  begin kind = 0; f = 38; end
         ENC_NOR:  begin kind = 0; f = 39; end
         ENC_SLT:  begin kind = 0; f = 42; end
         ENC_ADDM: begin kind = 0; f = 44; end
         ENC_JR:   begin kind = 1; end
         ENC_ADDI: begin o = 8;  if (sx) n = 0; end
         ENC_ANDI: begin o = 12; if (zx) n = 0; end
         ENC_ORI:  begin o = 13; if (zx) n = 0; end
         ENC_XORI: begin o = 14; if (zx) n = 0; end
         ENC_LW:   begin o = 35; if (sx) n = 0; end
         ENC_LBU:  begin o = 36; if (sx) n = 0; end
         ENC_SW:   begin o = 43; if (sx) n = 0; end
         ENC_SB:   begin o = 40; if (sx) n = 0; end
         ENC_BEQ:  begin o = 4;  if (sx) n = 0; end
         ENC_BNE:  begin o = 5;  if (sx) n = 0; end
         ENC_LUI:  begin kind = 3; if (zx) n = 0; end
         ENC_J:    begin kind = 4; if (jx) n = 0; end
         ENC_LI:   kind = 5;
         default:  n = 0;
      endcase
      case (kind)
         0: w0 = s * 2097152 + t * 65536 + d * 2048 + f;
         1: w0 = s * 2097152 + 8;
         2: w0 = o * 67108864 + s * 2097152 + t * 65536 + lo;
         3: w0 = 15 * 67108864 + t * 65536 + lo;
         4: w0 = 2 * 67108864 + (imm % 268435456) / 4;
         default: begin
            if (hi == 0) begin
               w0 = 13 * 67108864 + t * 65536 + lo;
            end else begin
               n  = 2;
               w0 = 15 * 67108864 + t * 65536 + hi;
               w1 = 13 * 67108864 + t * 2097152
                    + t * 65536 + lo;
            end
         end
      endcase
   endfunction

   // One cycle: drive, check against the scoreboard, advance the model.
   task automatic step(input logic        rv,
                       input logic [4:0]  op,
                       input logic [4:0]  rs,
                       input logic [4:0]  rt,
                       input logic [4:0]  rd,
                       input logic [31:0] imm,
                       input logic        ir);
      int          n;
      logic [31:0] w0, w1;
      logic        rdy;
      @(negedge clk);
      req_valid  = rv;
      req_op     = op;
      req_rs     = rs;
      req_rt     = rt;
      req_rd     = rd;
      req_imm    = imm;
      inst_ready = ir;
      #1;
      rdy = (q.size() == 0) || (q.size() == 1 && ir);
      chk("err", {31'd0, err}, {31'd0, err_exp});
      chk("count", {16'd0, inst_count}, {16'd0, cnt_exp});
      chk("valid", {31'd0, inst_valid},
          {31'd0, q.size() != 0});
      chk("req_ready", {31'd0, req_ready}, {31'd0, rdy});
      if (q.size() != 0) begin
         chk("inst", inst, q[0][31:0]);
         chk("last", {31'd0, inst_last}, {31'd0, q[0][32]});
      end
      err_exp = 1'b0;
      if (q.size() != 0 && ir) begin
         void'(q.pop_front());
         cnt_exp++;
      end
      if (rv && rdy) begin
         ref_enc(op, rs, rt, rd, imm, n, w0, w1);
         if (n == 0) err_exp = 1'b1;
         if (n == 1) q.push_back({1'b1, w0});
         if (n == 2) begin
            q.push_back({1'b0, w0});
            q.push_back({1'b1, w1});
         end
      end
   endtask

   task automatic idle(input logic ir);
      step(1'b0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, ir);
   endtask

   initial begin
      logic [31:0] imm;
      logic [4:0]  op;
      reset      = 1'b1;
      req_valid  = 1'b0;
      req_op     = '0;
      req_rs     = '0;
      req_rt     = '0;
      req_rd     = '0;
      req_imm    = '0;
      inst_ready = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_last", {31'd0, inst_last}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_count", {16'd0, inst_count}, 32'd0);
      chk("rst_ready", {31'd0, req_ready}, 32'd1);
      reset = 1'b0;

      // ADD $3,$1,$2
      step(1'b1, ENC_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1);
      idle(1'b1);
      chk("add_word", inst, 32'h0022_1820);
      chk("add_last", {31'd0, inst_last}, 32'd1);
      idle(1'b0);
      chk("add_count", {16'd0, inst_count}, 32'd1);

      // LI two-word and one-word forms
      step(1'b1, ENC_LI, 5'd0, 5'd8, 5'd0, 32'h1234_5678, 1'b1);
      idle(1'b1);
      chk("li_hi", inst, 32'h3C08_1234);
      chk("li_hi_rdy", {31'd0, req_ready}, 32'd0);
      step(1'b1, ENC_LI, 5'd0, 5'd8, 5'd0, 32'h0000_5678, 1'b1);
      chk("li_lo", inst, 32'h3508_5678);
      chk("li_lo_last", {31'd0, inst_last}, 32'd1);
      idle(1'b1);
      chk("li_short", inst, 32'h3408_5678);

      // back-to-back, no bubble
      step(1'b1, ENC_ADDI, 5'd0, 5'd4, 5'd0, 32'hFFFF_FFFF, 1'b1);
      step(1'b1, ENC_BEQ, 5'd1, 5'd2, 5'd0, 32'd3, 1'b1);
      chk("addi_word", inst, 32'h2004_FFFF);
      idle(1'b1);
      chk("beq_word", inst, 32'h1022_0003);

      // stall with a word held, then an undefined op
      step(1'b1, ENC_SUB, 5'd5, 5'd6, 5'd7, 32'd0, 1'b0);
      repeat (3) idle(1'b0);
      step(1'b1, 5'd25, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
      idle(1'b0);
      chk("undef_err", {31'd0, err}, 32'd1);
      idle(1'b0);
      chk("undef_valid", {31'd0, inst_valid}, 32'd0);

      // out-of-range ADDI immediate
      step(1'b1, ENC_ADDI, 5'd0, 5'd4, 5'd0, 32'd40000, 1'b1);
      idle(1'b1);
`ifdef MIPS_ENCODE_RANGE_CHECK_EN
      chk("range_err", {31'd0, err}, 32'd1);
`else
      chk("range_word", inst, 32'h2004_9C40);
`endif
      idle(1'b1);

      // reset in the middle of a two-word LI
      step(1'b1, ENC_LI, 5'd0, 5'd9, 5'd0, 32'hABCD_0001, 1'b0);
      idle(1'b0);
      reset = 1'b1;
      #1;
      chk("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
      q.delete();
      cnt_exp = '0;
      err_exp = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (3) idle(1'b1);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         op = 5'($urandom_range(0, 27));
         case ($urandom_range(0, 3))
            0: imm = 32'($urandom_range(0, 65535)) - 32'd32768;
            1: imm = $urandom;
            2: imm = 32'($urandom_range(0, 65535));
            default: imm = $urandom & 32'h0FFF_FFFC;
         endcase
         step($urandom_range(0, 3) != 0, op,
              5'($urandom), 5'($urandom), 5'($urandom),
              imm, $urandom_range(0, 3) != 0);
      end
      repeat (4) idle(1'b1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
